// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_ctrl (with half_substractor leaf cell)
// Brief    : Bit-serial LSB-first add/subtract sequencer using one 1-bit cell.
// Revision : 1.0 - initial release
// ============================================================================

module half_substractor (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_b
);
  assign o_d = i_x ^ i_y;
  assign o_b = ~i_x & i_y;
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op, r_carry, r_cout, r_busy, r_done;
  logic             w_p, w_d1, w_b1, w_d2, w_b2, w_s, w_c, w_last;

  // Adding is subtracting with x inverted: borrow(~x,y,c) == carry(x,y,c),
  // and the difference bit comes out inverted, so both are fixed up by op.
  assign w_p = r_a[0] ^ ~r_op;

  half_substractor u_hs0 (.i_x(w_p),  .i_y(r_b[0]),  .o_d(w_d1), .o_b(w_b1));
  half_substractor u_hs1 (.i_x(w_d1), .i_y(r_carry), .o_d(w_d2), .o_b(w_b2));

  assign w_c    = w_b1 | w_b2;
  assign w_s    = w_d2 ^ ~r_op;
  assign w_last = (r_cnt == C_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= op;
        r_work  <= '0;
        r_cnt   <= '0;
        r_carry <= 1'b0;
      end
    end else if (r_state == S_SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_work  <= {w_s, r_work[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= {w_s, r_work[WIDTH-1:1]};
        r_cout   <= w_c;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_ctrl
// Brief    : Directed and random checks of serial_addsub_ctrl at WIDTH 8 and 16.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_addsub_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, op8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, result8;
  logic        busy8, done8, cout8;
  logic        start16 = 1'b0, op16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, result16;
  logic        busy16, done16, cout16;
  logic        sel16 = 1'b0;
  logic        m_busy, m_done, m_cout;
  logic [15:0] m_result;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8)
  );

  serial_addsub_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16)
  );

  assign m_busy   = sel16 ? busy16   : busy8;
  assign m_done   = sel16 ? done16   : done8;
  assign m_cout   = sel16 ? cout16   : cout8;
  assign m_result = sel16 ? result16 : {8'h00, result8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] va, input logic [15:0] vb,
                       input logic vop);
    if (sel16) begin
      start16 = st; a16 = va; b16 = vb; op16 = vop;
    end else begin
      start8 = st; a8 = va[7:0]; b8 = vb[7:0]; op8 = vop;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vop, input logic [15:0] exp_r, input logic exp_c);
    int w;
    int lat;
    w   = sel16 ? 16 : 8;
    lat = 0;
    @(negedge clk);
    drive(1'b1, va, vb, vop);
    @(posedge clk); #1;
    drive(1'b0, ~va, ~vb, ~vop);
    check({tag, "_busy"}, 32'(m_busy), 32'd1);
    while (lat < w + 6 && !m_done) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(w));
    check({tag, "_result"}, 32'(m_result), 32'(exp_r));
    check({tag, "_cout"}, 32'(m_cout), 32'(exp_c));
    check({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(m_done), 32'd0);
  endtask

  // Back-to-back ops with start held high; each new operand set is presented
  // right after a done, so it is accepted at the first IDLE edge.
  task automatic stream(input int n);
    int          w;
    int          gap;
    int          waited;
    logic [15:0] mask, ra, rb, er;
    logic        ro, ec;
    logic [16:0] full;
    w    = sel16 ? 16 : 8;
    mask = sel16 ? 16'hFFFF : 16'h00FF;
    gap  = 0;
    ra = 16'($urandom) & mask; rb = 16'($urandom) & mask; ro = 1'($urandom);
    @(negedge clk);
    drive(1'b1, ra, rb, ro);
    for (int k = 0; k < n; k++) begin
      full = ro ? ({1'b0, ra} - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
      er   = full[15:0] & mask;
      ec   = full[w];
      waited = 0;
      do begin
        @(posedge clk); #1;
        gap++;
        waited++;
      end while (!m_done && waited < w + 8);
      check("rnd_result", 32'(m_result), 32'(er));
      check("rnd_cout", 32'(m_cout), 32'(ec));
      if (k > 0) check("rnd_spacing", 32'(gap), 32'(w + 2));
      gap = 0;
      ra = 16'($urandom) & mask; rb = 16'($urandom) & mask; ro = 1'($urandom);
      @(negedge clk);
      drive((k == n - 1) ? 1'b0 : 1'b1, ra, rb, ro);
    end
    repeat (w + 4) @(posedge clk);
  endtask

  initial begin
    int          n_done;
    logic [15:0] cap_r;
    logic        cap_c;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_result16", 32'(result16), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(busy8), 32'd0);
      check("idle_done", 32'(done8), 32'd0);
    end

    do_op("add_5a_3c", 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0);
    do_op("add_ff_01", 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1);
    do_op("sub_10_01", 16'h10, 16'h01, 1'b1, 16'h0F, 1'b0);
    do_op("sub_00_01", 16'h00, 16'h01, 1'b1, 16'hFF, 1'b1);
    do_op("sub_80_80", 16'h80, 16'h80, 1'b1, 16'h00, 1'b0);

    // start pulses during SHIFT and during DONE must both be ignored
    @(negedge clk);
    drive(1'b1, 16'h12, 16'h34, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'h12, 16'h34, 1'b0);
    n_done = 0;
    cap_r  = '0;
    cap_c  = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 3 || (m_done && n_done == 0)) drive(1'b1, 16'hFF, 16'hFF, 1'b1);
      else drive(1'b0, 16'hFF, 16'hFF, 1'b1);
      if (m_done) begin
        n_done++;
        cap_r = m_result;
        cap_c = m_cout;
      end
    end
    check("ignore_done_count", 32'(n_done), 32'd1);
    check("ignore_result", 32'(cap_r), 32'h46);
    check("ignore_cout", 32'(cap_c), 32'd0);

    // asynchronous reset in the middle of a SHIFT
    @(negedge clk);
    drive(1'b1, 16'hAA, 16'h55, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'hAA, 16'h55, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_result", 32'(result8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    do_op("add_01_01", 16'h01, 16'h01, 1'b0, 16'h02, 1'b0);

    stream(1000);
    sel16 = 1'b1;
    do_op("add16_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("sub16_1234_4321", 16'h1234, 16'h4321, 1'b1, 16'hCF13, 1'b1);
    stream(1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract sequencer wrapping a single 1-bit full-adder/full-subtractor cell built from `half_substractor` instances. It accepts two WIDTH-bit operands and an op select on a start pulse. It streams one bit per clock, LSB first, through the cell while holding carry/borrow in a flip-flop. It then presents a registered result with a one-cycle done pulse. It is the team's area-minimal arithmetic unit for control paths where latency is not critical.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CNT_W, $clog2(WIDTH), bit-index counter width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = A+B, 1 = A−B; captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  last completed sum/difference; held until next completion
- cout  output  1  final carry (add) or final borrow (sub); held with result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start=1 at an edge:
  - load A and B shift registers;
  - latch op;
  - clear bit counter and working result register;
  - clear the carry/borrow flop to 0, for both add and sub.
- In IDLE with start=0, the state stays IDLE.
- SHIFT, each cycle:
  - the cell takes x=A[0], y=B[0], c=carry flop.
  - Add: s = x^y^c; c' = (x&y) | ((x^y)&c).
  - Sub: d = x^y^c; c' = (~x&y) | (~(x^y)&c), which is the borrow.
  - At the edge: shift the s/d bit into the working register MSB (shift right); shift A and B right; carry flop ← c'; counter +1.
- SHIFT → DONE at the edge where counter == WIDTH−1, i.e. after exactly WIDTH SHIFT cycles. At that same edge:
  - result ← final working value;
  - cout ← final c'.
- DONE → IDLE unconditionally after one cycle. start asserted during DONE is ignored; it must be reasserted in IDLE.
- start during SHIFT or DONE is ignored, and a/b/op changes have no effect on the operation in flight.
- Arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH−1 (add) or the borrow out of bit WIDTH−1 (sub, 1 iff A<B unsigned). No signed overflow flag.
- Reset (any time, including mid-SHIFT), asynchronous:
  - state=IDLE, busy=0, done=0, result=0, cout=0;
  - counter, carry flop, operand and working registers all 0;
  - the in-flight operation is discarded with no done pulse.
  - First start is accepted at the first edge after rst deasserts.

## Timing
- start sampled high at edge k (in IDLE): busy=1 from after edge k through edge k+WIDTH.
- result/cout update at edge k+WIDTH; done=1 and busy=0 for the cycle between edges k+WIDTH and k+WIDTH+1.
- Back at IDLE after edge k+WIDTH+1. Earliest next start is sampled at edge k+WIDTH+2, giving a throughput of one op per WIDTH+2 cycles.
- Latency from start edge to done: WIDTH cycles.
- busy and done are never high together. Both are registered, with no combinational path from inputs.
- result/cout never change except at a completion edge or at reset.

## Test plan
- Reset then idle, WIDTH=8: all outputs 0; start held low for 20 cycles → busy and done stay 0.
- Add 0x5A+0x3C: done exactly 8 cycles after the start edge with result=0x96, cout=0. Then 0xFF+0x01 → result=0x00, cout=1.
- Sub 0x10−0x01 → result=0x0F, cout=0. Sub 0x00−0x01 → result=0xFF, cout=1. Sub 0x80−0x80 → result=0x00, cout=0.
- Start 0x12+0x34, then pulse start with a=0xFF, b=0xFF, op=1 during SHIFT and again during DONE → exactly one done, result=0x46; the second op is never executed.
- Assert rst at SHIFT cycle 4 of 0xAA+0x55 → outputs go 0 immediately, no done pulse. A fresh 0x01+0x01 then yields result=0x02, cout=0.
- Random sweep: 1000 random a/b/op at WIDTH=8 and WIDTH=16, checked against a (a±b) mod 2^WIDTH reference model for result and cout, plus the done-to-start spacing ≥ WIDTH+2.
